// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared encodings and helpers for the mem_lsu load/store unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    ST_WR  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// lsu_lane_align : combinational load lane extraction/extension and store merge
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  off,
  input  logic [31:0] rd_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rd_word[{off, 3'b000} +: LANE_W];
  assign half_lane = rd_word[{off[1], 4'b0000} +: 2*LANE_W];

  always_comb begin
    ld_data = rd_word;
    case (size)
      SZ_B:    ld_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_H:    ld_data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: ld_data = rd_word;
    endcase
  end

  // Unaddressed bytes pass through from the word read back before the write.
  always_comb begin
    merge_data = base_word;
    case (size)
      SZ_B:    merge_data[{off, 3'b000} +: LANE_W]       = wdata[7:0];
      SZ_H:    merge_data[{off[1], 4'b0000} +: 2*LANE_W] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// mem_lsu : byte/half/word load-store unit in front of a 1 KiB data memory
// Optional build macro LSU_MISALIGN_EN : allow misaligned half/word accesses
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wrdata,
  input  logic [DW-1:0] mem_rddata
);

  state_t        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req_mis;
  logic          req_err;
  logic [1:0]    acc_off;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] merge_data;
  logic          mem_state;

  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

`ifdef LSU_MISALIGN_EN
  localparam logic [AW-1:0] TOP_WIN = AW'((1 << AW) - 4);
  logic acc_mis;

  // A misaligned window must still fit below the top of memory.
  assign req_err  = (req_size == SZ_X) || (req_mis && (req_addr > TOP_WIN));
  assign acc_mis  = is_misaligned(size_q, addr_q[1:0]);
  assign acc_off  = acc_mis ? 2'b00 : addr_q[1:0];
  assign acc_addr = acc_mis ? addr_q : {addr_q[AW-1:2], 2'b00};
`else
  assign req_err  = (req_size == SZ_X) || req_mis;
  assign acc_off  = addr_q[1:0];
  assign acc_addr = {addr_q[AW-1:2], 2'b00};
`endif

  lsu_lane_align u_align (
    .size       (size_q),
    .sign_ext   (signed_q),
    .off        (acc_off),
    .rd_word    (mem_rddata),
    .base_word  (merge_q),
    .wdata      (wdata_q),
    .ld_data    (ld_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          rdata_d  = '0;
          if (req_err)               state_d = RESP;
          else if (!req_we)          state_d = LD;
          else if (req_size == SZ_W) state_d = ST_WR;
          else                       state_d = RMW_RD;
        end
      end
      LD: begin
        rdata_d = ld_data;
        state_d = RESP;
      end
      ST_WR:  state_d = RESP;
      RMW_RD: begin
        merge_d = mem_rddata;
        state_d = RMW_WR;
      end
      RMW_WR: state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_state  = (state_q == LD) || (state_q == ST_WR) ||
                      (state_q == RMW_RD) || (state_q == RMW_WR);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  // Strobes drop with reset so an aborted request never touches memory.
  assign mem_read   = !reset && ((state_q == LD) || (state_q == RMW_RD));
  assign mem_write  = !reset && ((state_q == ST_WR) || (state_q == RMW_WR));
  assign mem_addr   = mem_state ? acc_addr : '0;
  assign mem_wrdata = (state_q == ST_WR)  ? wdata_q :
                      (state_q == RMW_WR) ? merge_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// tb_mem_lsu : directed self-checking bench for mem_lsu with a byte memory model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_write;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wrdata;
  logic [31:0]   mem_rddata;

  logic [7:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  int resp_cnt = 0;

  mem_lsu #(.AW(AW), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_rddata (mem_rddata)
  );

  always #5 clk = ~clk;

  assign mem_rddata = mem_read ? {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                                  mem[mem_addr + 10'd1], mem[mem_addr]} : 32'h0;

  always @(posedge clk) begin
    if (mem_write && !mem_read) begin
      mem[mem_addr]          <= mem_wrdata[7:0];
      mem[mem_addr + 10'd1]  <= mem_wrdata[15:8];
      mem[mem_addr + 10'd2]  <= mem_wrdata[23:16];
      mem[mem_addr + 10'd3]  <= mem_wrdata[31:24];
    end
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write && mem_read) both_cnt <= both_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response pulse.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int strobes);
    int s0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    s0 = wr_cnt + rd_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = 99;
    rdata = 32'hxxxxxxxx;
    err   = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat   = i;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
    strobes = wr_cnt + rd_cnt - s0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stb;
    int          w0;
    int          rc;

    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wrdata", mem_wrdata, 32'd0);

    do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, rd, er, lat, stb);
    check("sw_lat", lat, 2);
    check("sw_err_rdata", {er, rd[30:0]} | {1'b0, rd[31], 30'd0}, 32'd0);
    @(negedge clk);
    check("sw_resp_one_cycle", {31'd0, resp_valid}, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, rd, er, lat, stb);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, er}, 32'd0);
    check("lw_lat", lat, 2);

    do_req(1'b1, 2'b00, 1'b0, 10'h012, 32'h0000005A, rd, er, lat, stb);
    check("sb_lat", lat, 3);
    check("sb_strobes", stb, 2);
    check("sb_no_overlap", both_cnt, 0);

    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, rd, er, lat, stb);
    check("lw_after_sb", rd, 32'hDE5ABEEF);

    do_req(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, rd, er, lat, stb);
    check("lb_signed", rd, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, rd, er, lat, stb);
    check("lb_unsigned", rd, 32'h000000DE);
    do_req(1'b0, 2'b00, 1'b1, 10'h010, 32'h0, rd, er, lat, stb);
    check("lb_signed_lane0", rd, 32'hFFFFFFEF);
    do_req(1'b0, 2'b01, 1'b1, 10'h012, 32'h0, rd, er, lat, stb);
    check("lh_signed", rd, 32'hFFFFDE5A);
    do_req(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, rd, er, lat, stb);
    check("lh_unsigned_lo", rd, 32'h0000BEEF);

    do_req(1'b0, 2'b10, 1'b0, 10'h011, 32'h0, rd, er, lat, stb);
`ifdef LSU_MISALIGN_EN
    check("lw_mis_data", rd, 32'h00DE5ABE);
    check("lw_mis_err", {31'd0, er}, 32'd0);
`else
    check("lw_mis_err", {31'd0, er}, 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    check("lw_mis_strobes", stb, 0);
    check("lw_mis_lat", lat, 1);
    do_req(1'b0, 2'b01, 1'b0, 10'h011, 32'h0, rd, er, lat, stb);
    check("lh_mis_err", {31'd0, er}, 32'd1);
`endif

    do_req(1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0, rd, er, lat, stb);
    check("lw_top_err", {31'd0, er}, 32'd1);
    check("lw_top_strobes", stb, 0);

    do_req(1'b1, 2'b10, 1'b0, 10'h3FC, 32'h01020304, rd, er, lat, stb);
    check("sw_top_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, rd, er, lat, stb);
    check("lw_top_data", rd, 32'h01020304);

    do_req(1'b0, 2'b11, 1'b0, 10'h020, 32'h0, rd, er, lat, stb);
    check("ill_ld_err", {31'd0, er}, 32'd1);
    check("ill_ld_rdata", rd, 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 10'h024, 32'hFFFFFFFF, rd, er, lat, stb);
    check("ill_st_err", {31'd0, er}, 32'd1);
    check("ill_st_strobes", stb, 0);

    do_req(1'b1, 2'b01, 1'b0, 10'h012, 32'h1234A5C3, rd, er, lat, stb);
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, rd, er, lat, stb);
    check("sh_merge", rd, 32'hA5C3BEEF);

    // Abort a byte store while it is in its write-back cycle.
    do_req(1'b1, 2'b10, 1'b0, 10'h040, 32'h11223344, rd, er, lat, stb);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 10'h041;
    req_wdata = 32'h000000FF;
    rc = resp_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_strobe", {30'd0, mem_write, mem_read}, 32'd1);
    @(negedge clk);
    check("rmw_wr_strobe", {30'd0, mem_write, mem_read}, 32'd2);
    reset = 1'b1;
    #1;
    check("rst_gates_write", {31'd0, mem_write}, 32'd0);
    w0 = wr_cnt;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("abort_no_write", wr_cnt, w0);
    check("abort_no_resp", resp_cnt, rc);
    do_req(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, rd, er, lat, stb);
    check("abort_word_intact", rd, 32'h11223344);

    check("never_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
